// File: rtl/dff_reg_16bits.sv
// 16-bit enabled D register, one flop per bit, synchronous active-low reset.
// Define DFF_REG_16BITS_PARITY_EN to add the registered even-parity output Q_PAR.
module dff_reg_16bits #(
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic CE,
    input  logic D_15,
    input  logic D_14,
    input  logic D_13,
    input  logic D_12,
    input  logic D_11,
    input  logic D_10,
    input  logic D_9,
    input  logic D_8,
    input  logic D_7,
    input  logic D_6,
    input  logic D_5,
    input  logic D_4,
    input  logic D_3,
    input  logic D_2,
    input  logic D_1,
    input  logic D_0,
    output logic Q_15,
    output logic Q_14,
    output logic Q_13,
    output logic Q_12,
    output logic Q_11,
    output logic Q_10,
    output logic Q_9,
    output logic Q_8,
    output logic Q_7,
    output logic Q_6,
    output logic Q_5,
    output logic Q_4,
    output logic Q_3,
    output logic Q_2,
    output logic Q_1,
    output logic Q_0
`ifdef DFF_REG_16BITS_PARITY_EN
    ,
    output logic Q_PAR
`endif
);

    localparam int unsigned W = 16;

    logic [W-1:0] d_vec;
    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    assign d_vec = {D_15, D_14, D_13, D_12, D_11, D_10, D_9, D_8,
                    D_7,  D_6,  D_5,  D_4,  D_3,  D_2,  D_1, D_0};

    // Enable mux: load D when CE is high, otherwise recirculate the stored word.
    always_comb begin
        data_d = data_q;
        if (CE) begin
            data_d = d_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign {Q_15, Q_14, Q_13, Q_12, Q_11, Q_10, Q_9, Q_8,
            Q_7,  Q_6,  Q_5,  Q_4,  Q_3,  Q_2,  Q_1, Q_0} = data_q;

`ifdef DFF_REG_16BITS_PARITY_EN
    logic par_d;
    logic par_q;

    // Parity is computed from D so it tracks the stored word without adding a Q-side XOR tree.
    always_comb begin
        par_d = par_q;
        if (CE) begin
            par_d = ^d_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= ^RESET_VALUE;
        end else begin
            par_q <= par_d;
        end
    end

    assign Q_PAR = par_q;
`endif

endmodule

// File: tb/tb_dff_reg_16bits.sv
// Randomized self-checking bench for dff_reg_16bits against a word-level model.
// Covers Q_PAR too when DFF_REG_16BITS_PARITY_EN is defined.
module tb_dff_reg_16bits;

    localparam logic [15:0] RV = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [15:0] d_in;
    wire  [15:0] q_obs;
`ifdef DFF_REG_16BITS_PARITY_EN
    wire         q_par_obs;
`endif

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [15:0] exp_q;

    always #5 clk = ~clk;

    dff_reg_16bits #(.RESET_VALUE(RV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .CE    (ce),
        .D_15  (d_in[15]), .D_14 (d_in[14]), .D_13 (d_in[13]), .D_12 (d_in[12]),
        .D_11  (d_in[11]), .D_10 (d_in[10]), .D_9  (d_in[9]),  .D_8  (d_in[8]),
        .D_7   (d_in[7]),  .D_6  (d_in[6]),  .D_5  (d_in[5]),  .D_4  (d_in[4]),
        .D_3   (d_in[3]),  .D_2  (d_in[2]),  .D_1  (d_in[1]),  .D_0  (d_in[0]),
        .Q_15  (q_obs[15]), .Q_14 (q_obs[14]), .Q_13 (q_obs[13]), .Q_12 (q_obs[12]),
        .Q_11  (q_obs[11]), .Q_10 (q_obs[10]), .Q_9  (q_obs[9]),  .Q_8  (q_obs[8]),
        .Q_7   (q_obs[7]),  .Q_6  (q_obs[6]),  .Q_5  (q_obs[5]),  .Q_4  (q_obs[4]),
        .Q_3   (q_obs[3]),  .Q_2  (q_obs[2]),  .Q_1  (q_obs[1]),  .Q_0  (q_obs[0])
`ifdef DFF_REG_16BITS_PARITY_EN
        ,
        .Q_PAR (q_par_obs)
`endif
    );

    // Drive inputs mid-period, advance one rising edge, update the model, sample 1 ns later.
    task automatic step(input logic rst, input logic c, input logic [15:0] d);
        @(negedge clk);
        rst_n = rst;
        ce    = c;
        d_in  = d;
        @(posedge clk);
        if (!rst)   exp_q = RV;
        else if (c) exp_q = d;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 16'hFFFF);
            n_total++;
            if (q_obs !== RV) $display("FAIL reset_q[%0d]: got %h want %h", i, q_obs, RV);
            else n_pass++;
        end
`ifdef DFF_REG_16BITS_PARITY_EN
        n_total++;
        if (q_par_obs !== 1'b0) $display("FAIL reset_par: got %b want 0", q_par_obs);
        else n_pass++;
`endif
    endtask

    task automatic test_load_ramp();
        for (int v = 1; v <= 16; v++) begin
            step(1'b1, 1'b1, 16'(v));
            n_total++;
            if (q_obs !== exp_q) $display("FAIL ramp_q[%0d]: got %h want %h", v, q_obs, exp_q);
            else n_pass++;
        end
        n_total++;
        if (q_obs !== 16'h0010) $display("FAIL ramp_end: got %h want 0010", q_obs);
        else n_pass++;
    endtask

    task automatic test_hold();
        for (int v = 15; v >= 0; v--) begin
            step(1'b1, 1'b0, 16'(v));
            n_total++;
            if (q_obs !== 16'h0010) $display("FAIL hold_q[%0d]: got %h want 0010", v, q_obs);
            else n_pass++;
        end
    endtask

    task automatic test_latency();
        logic [15:0] a;
        logic [15:0] b;
        a = 16'($urandom);
        b = ~a;
        step(1'b1, 1'b1, a);
        // Inputs wiggle between edges; nothing may reach Q before the next edge.
        d_in = b;
        #2;
        n_total++;
        if (q_obs !== a) $display("FAIL latency_mid: got %h want %h", q_obs, a);
        else n_pass++;
        d_in  = 16'($urandom);
        #1 d_in = b;
        ce    = 1'b0;
        #1 ce = 1'b1;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        n_total++;
        if (q_obs !== a) $display("FAIL glitch_mid: got %h want %h", q_obs, a);
        else n_pass++;
        @(posedge clk);
        exp_q = b;
        #1;
        n_total++;
        if (q_obs !== b) $display("FAIL latency_edge: got %h want %h", q_obs, b);
        else n_pass++;
    endtask

    task automatic test_reset_priority();
        step(1'b1, 1'b1, 16'hA5A5);
        n_total++;
        if (q_obs !== 16'hA5A5) $display("FAIL prio_load: got %h want a5a5", q_obs);
        else n_pass++;
        step(1'b0, 1'b1, 16'h1234);
        n_total++;
        if (q_obs !== 16'h0000) $display("FAIL prio_reset: got %h want 0000", q_obs);
        else n_pass++;
    endtask

`ifdef DFF_REG_16BITS_PARITY_EN
    task automatic test_parity();
        step(1'b1, 1'b1, 16'h0001);
        n_total++;
        if (q_par_obs !== 1'b1) $display("FAIL par_0001: got %b want 1", q_par_obs);
        else n_pass++;
        step(1'b1, 1'b1, 16'h0003);
        n_total++;
        if (q_par_obs !== 1'b0) $display("FAIL par_0003: got %b want 0", q_par_obs);
        else n_pass++;
        step(1'b1, 1'b0, 16'h0007);
        n_total++;
        if (q_par_obs !== 1'b0 || q_obs !== 16'h0003)
            $display("FAIL par_hold: got par=%b q=%h want par=0 q=0003", q_par_obs, q_obs);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 7) != 0), 1'($urandom), 16'($urandom));
            n_total++;
            if (q_obs !== exp_q) $display("FAIL rand_q[%0d]: got %h want %h", i, q_obs, exp_q);
            else n_pass++;
`ifdef DFF_REG_16BITS_PARITY_EN
            n_total++;
            if (q_par_obs !== ^exp_q)
                $display("FAIL rand_par[%0d]: got %b want %b", i, q_par_obs, ^exp_q);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ce    = 1'b0;
        d_in  = 16'h0000;
        exp_q = RV;
        test_reset();
        test_load_ramp();
        test_hold();
        test_latency();
        test_reset_priority();
`ifdef DFF_REG_16BITS_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/dff_reg_16bits.md
DFF_REG_16BITS -- requirements
Module: dff_reg_16bits

Interface
REQ-001 Parameter: RESET_VALUE, default 16'h0000, the value loaded into Q_15..Q_0 on reset.
REQ-002 Ports: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Ports: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Ports: CE  input  1  clock enable; 1 loads D, 0 holds Q.
REQ-005 Ports: D_15..D_0  input  1 each  data bits, D_15 = MSB, D_0 = LSB.
REQ-006 Ports: Q_15..Q_0  output  1 each  registered data bits, Q_i corresponds to D_i.
REQ-007 Ports (only when DFF_REG_16BITS_PARITY_EN is defined): Q_PAR  output  1  registered even parity of the stored word.

Function
REQ-008 Each bit SHALL be an independent D flip-flop with enable, forming one 16-bit register.
REQ-009 On a rising clk edge with rst_n=1 and CE=1, Q_i SHALL take the value of D_i sampled at that edge, for all i.
REQ-010 On a rising clk edge with rst_n=1 and CE=0, every Q_i SHALL hold its previous value regardless of D.
REQ-011 Load latency SHALL be exactly one clock edge; there SHALL be no combinational path from D_i, CE or rst_n to any output.
REQ-012 Changes on D or CE between edges SHALL have no effect on Q until the next rising edge.
REQ-013 Bit mapping SHALL be strict: D_i drives only Q_i, with no reordering, sign handling or arithmetic.
REQ-014 Outputs SHALL be driven directly by flip-flops (glitch-free).

Reset
REQ-015 On a rising clk edge with rst_n=0, Q_15..Q_0 SHALL load RESET_VALUE bit-for-bit, and Q_PAR (if present) SHALL load the XOR of RESET_VALUE.
REQ-016 Reset SHALL take priority over CE; CE=1 with rst_n=0 still resets.
REQ-017 Assertion of rst_n between edges SHALL have no effect until the next rising edge (synchronous reset).
REQ-018 Outputs before the first reset edge are undefined; the bench SHALL apply reset before checking.

Configuration
REQ-019 Macro DFF_REG_16BITS_PARITY_EN: when defined, the Q_PAR port and flip-flop SHALL exist.
REQ-020 Q_PAR SHALL load the XOR of D_15..D_0 under the same CE/reset conditions as Q, so that Q_PAR always equals the XOR of Q_15..Q_0.
REQ-021 When DFF_REG_16BITS_PARITY_EN is not defined, Q_PAR SHALL be absent and behaviour SHALL be identical to REQ-008..REQ-018.

Verification
REQ-022 Reset: rst_n=0 for 2 edges with CE=1 and D=16'hFFFF -> Q=RESET_VALUE (16'h0000) and Q_PAR=0.
REQ-023 Load ramp: rst_n=1, CE=1, clk period 10 ns, D incremented 16'h0001..16'h0010 once per cycle mid-period -> after each rising edge Q equals the D of that cycle, ending at Q=16'h0010.
REQ-024 Hold: after the ramp, CE=0 and D decremented 16'h000F..16'h0000 over 16 cycles -> Q stays 16'h0010 throughout.
REQ-025 Latency and glitch: change D mid-cycle with CE=1 -> Q is unchanged until the next rising edge; D pulsed between edges -> no Q change.
REQ-026 Reset priority: with Q=16'hA5A5, CE=1, D=16'h1234 and rst_n=0 at the edge -> Q=16'h0000.
REQ-027 Parity (macro defined): load 16'h0001 -> Q_PAR=1; load 16'h0003 -> Q_PAR=0; with CE=0 and D=16'h0007 -> Q_PAR holds 0.
